// File: rtl/pool_pkg.sv
// Shared float types and ordered-key max helpers for the ReLU/max-pool stage.
// NaN inputs are outside the supported range and give an undefined result.
package pool_pkg;

  localparam int unsigned FloatWidth = 32;

  typedef logic [FloatWidth-1:0] float_t;

  localparam float_t FLOAT_POS_ZERO = 32'h0000_0000;

  // Map IEEE-754 bits to an unsigned key that orders like the float values.
  function automatic float_t float_key(input float_t v);
    return v[FloatWidth-1] ? ~v : {1'b1, v[FloatWidth-2:0]};
  endfunction

  // On equal keys the first operand (the earlier sample) is kept.
  function automatic float_t float_max(input float_t a, input float_t b);
    return (float_key(b) > float_key(a)) ? b : a;
  endfunction

endpackage

// File: rtl/relu_maxpool2x2_stream_if.sv
// Sample stream into, and pooled stream out of, relu_maxpool2x2_stream.
// The slave modport belongs to the pooling block; master is the upstream/sink side.
interface relu_maxpool2x2_stream_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  frame_done;

  modport master (
    output valid_in, data_in,
    input  valid_out, data_out, frame_done
  );

  modport slave (
    input  valid_in, data_in,
    output valid_out, data_out, frame_done
  );
endinterface

// File: rtl/pool_line_buffer.sv
// Half-row buffer of horizontal pair maxima; one write port and one combinational
// read port sharing the same address. Contents are not reset.
module pool_line_buffer
  import pool_pkg::*;
#(
  parameter int unsigned Depth = 28,
  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  float_t           wdata_i,
  output float_t           rdata_o
);

  float_t mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/relu_maxpool2x2_stream.sv
// Streaming ReLU + 2x2/stride-2 max-pool over a raster float stream, no backpressure.
// Define POOL_RELU_EN to clamp negative samples to +0 before pooling.
module relu_maxpool2x2_stream
  import pool_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WIDTH      = 56,
  parameter int unsigned HEIGHT     = 56
) (
  input  logic                      clk,
  input  logic                      rst,
  relu_maxpool2x2_stream_if.slave   bus
);

  localparam int unsigned ColW    = $clog2(WIDTH);
  localparam int unsigned RowW    = $clog2(HEIGHT);
  localparam int unsigned LbDepth = WIDTH / 2;
  localparam int unsigned AddrW   = (LbDepth > 1) ? $clog2(LbDepth) : 1;

  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  float_t          hold_q, hold_d;
  float_t          data_out_q, data_out_d;
  logic            valid_out_q, valid_out_d;
  logic            frame_done_q, frame_done_d;

  float_t          x, pair_max, lb_rdata;
  logic            lb_we;
  logic            last_col, last_row;

  pool_line_buffer #(
    .Depth (LbDepth)
  ) u_line_buffer (
    .clk_i   (clk),
    .we_i    (lb_we),
    .addr_i  (AddrW'(col_q >> 1)),
    .wdata_i (pair_max),
    .rdata_o (lb_rdata)
  );

  always_comb begin
    x = float_t'(bus.data_in);
`ifdef POOL_RELU_EN
    if (x[FloatWidth-1]) begin
      x = FLOAT_POS_ZERO;
    end
`endif
    pair_max = float_max(hold_q, x);
    last_col = (col_q == ColW'(WIDTH - 1));
    last_row = (row_q == RowW'(HEIGHT - 1));
    lb_we    = bus.valid_in && col_q[0] && !row_q[0];

    col_d        = col_q;
    row_d        = row_q;
    hold_d       = hold_q;
    data_out_d   = data_out_q;
    valid_out_d  = 1'b0;
    frame_done_d = 1'b0;

    if (bus.valid_in) begin
      if (!col_q[0]) begin
        hold_d = x;
      end else if (row_q[0]) begin
        data_out_d   = float_max(lb_rdata, pair_max);
        valid_out_d  = 1'b1;
        frame_done_d = last_col && last_row;
      end

      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q        <= '0;
      row_q        <= '0;
      hold_q       <= FLOAT_POS_ZERO;
      data_out_q   <= FLOAT_POS_ZERO;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      hold_q       <= hold_d;
      data_out_q   <= data_out_d;
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.valid_out  = valid_out_q;
  assign bus.data_out   = DATA_WIDTH'(data_out_q);
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_relu_maxpool2x2_stream.sv
// Directed scoreboard bench for relu_maxpool2x2_stream on a 4x4 frame.
// Expectations follow POOL_RELU_EN when the bench is built with it defined.
module tb_relu_maxpool2x2_stream;

  localparam int unsigned W = 4;
  localparam int unsigned H = 4;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  relu_maxpool2x2_stream_if #(.DATA_WIDTH(32)) bus ();

  relu_maxpool2x2_stream #(
    .DATA_WIDTH (32),
    .WIDTH      (W),
    .HEIGHT     (H)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        sb[$];
  int          vectors;
  int          miscompares;
  logic        pending;
  logic [31:0] last_data;
  int          mcol, mrow;
  logic [31:0] top[W];
  logic [31:0] bot[W];

  logic [31:0] f1 [16] = '{
    32'h3E800000, 32'h40000000, 32'h3F800000, 32'h3E800000,
    32'h3F000000, 32'h3E800000, 32'h3E800000, 32'h3F000000,
    32'h3E800000, 32'h3F000000, 32'h3E800000, 32'h40000000,
    32'h3F000000, 32'h3E800000, 32'h3F000000, 32'h3E800000};
  logic [31:0] f_neg [16] = '{
    32'hBF800000, 32'hC0400000, 32'h3F800000, 32'h3E800000,
    32'hC0400000, 32'hBF800000, 32'h3E800000, 32'h3F000000,
    32'h3E800000, 32'h3F000000, 32'h3E800000, 32'h40000000,
    32'h3F000000, 32'h3E800000, 32'h3F000000, 32'h3E800000};
  logic [31:0] f_zero [16] = '{
    32'h00000000, 32'h80000000, 32'hBF800000, 32'hC0400000,
    32'hBF800000, 32'hC0400000, 32'hC0400000, 32'hBF800000,
    32'h3E800000, 32'h3E800000, 32'h3E800000, 32'h3E800000,
    32'h3E800000, 32'h3E800000, 32'h3E800000, 32'h3E800000};

  // a strictly greater than b as float values; +0 ranks above -0
  function automatic logic fgt(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return !a[31];
    if (!a[31]) return a[30:0] > b[30:0];
    return a[30:0] < b[30:0];
  endfunction

  function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b);
    return fgt(b, a) ? b : a;
  endfunction

  function automatic logic [31:0] relu(input logic [31:0] v);
`ifdef POOL_RELU_EN
    return v[31] ? 32'h0 : v;
`else
    return v;
`endif
  endfunction

  task automatic check_outputs();
    exp_t e;
    vectors++;
    assert (bus.valid_out === pending) else begin
      miscompares++;
      $error("FAIL valid_out: got %b want %b", bus.valid_out, pending);
    end
    if (pending) begin
      e = sb.pop_front();
      last_data = e.data;
      vectors++;
      assert (bus.data_out === e.data) else begin
        miscompares++;
        $error("FAIL data_out: got %h want %h", bus.data_out, e.data);
      end
      vectors++;
      assert (bus.frame_done === e.last) else begin
        miscompares++;
        $error("FAIL frame_done: got %b want %b", bus.frame_done, e.last);
      end
    end else begin
      vectors++;
      assert (bus.data_out === last_data && bus.frame_done === 1'b0) else begin
        miscompares++;
        $error("FAIL idle_hold: got data %h fd %b want data %h fd 0",
               bus.data_out, bus.frame_done, last_data);
      end
    end
  endtask

  task automatic cycle(input logic v, input logic [31:0] d);
    logic [31:0] x;
    exp_t        e;
    @(negedge clk);
    check_outputs();
    rst          = 1'b1;
    bus.valid_in = v;
    bus.data_in  = d;
    pending      = 1'b0;
    if (v) begin
      x = relu(d);
      if (mrow % 2 == 0) begin
        top[mcol] = x;
      end else begin
        bot[mcol] = x;
        if (mcol % 2 == 1) begin
          e.data = fmax(fmax(top[mcol-1], top[mcol]), fmax(bot[mcol-1], x));
          e.last = (mrow == H - 1) && (mcol == W - 1);
          sb.push_back(e);
          pending = 1'b1;
        end
      end
      if (mcol == W - 1) begin
        mcol = 0;
        mrow = (mrow == H - 1) ? 0 : mrow + 1;
      end else begin
        mcol++;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_outputs();
    rst          = 1'b0;
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    pending      = 1'b0;
    last_data    = '0;
    mcol         = 0;
    mrow         = 0;
    sb.delete();
  endtask

  task automatic send_frame(input logic [31:0] f [16], input int max_gap);
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, max_gap)) cycle(1'b0, $urandom);
      cycle(1'b1, f[i]);
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    pending      = 1'b0;
    last_data    = '0;
    mcol         = 0;
    mrow         = 0;
    rst          = 1'b0;
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    repeat (2) @(negedge clk);

    // Reset state, then a contiguous frame
    do_reset();
    cycle(1'b0, 32'h0);
    send_frame(f1, 0);
    repeat (2) cycle(1'b0, 32'h0);

    // Same frame with random idle gaps
    send_frame(f1, 3);
    repeat (2) cycle(1'b0, 32'h0);

    // Negative top-left window
    send_frame(f_neg, 0);
    repeat (2) cycle(1'b0, 32'h0);

    // Abort after sample #7, then a fresh frame
    for (int i = 0; i < 7; i++) cycle(1'b1, f1[i]);
    do_reset();
    send_frame(f1, 0);

    // Back-to-back frames, second one small-valued
    send_frame(f_neg, 0);
    send_frame(f_zero, 1);
    repeat (3) cycle(1'b0, 32'h0);

    vectors++;
    assert (sb.size() == 0) else begin
      miscompares++;
      $error("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
